// File: rtl/button_event_if.sv
// Event bus between the button arbiter and the game FSM: press inputs in,
// serialised valid/ready events and status out.
interface button_event_if #(
  parameter int N_BTN = 4,
  parameter int DEPTH = 4,
  parameter int ID_W  = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             enable;
  logic [N_BTN-1:0] btn_edge;
  logic             evt_ready;
  logic             clr_ovf;
  logic             evt_valid;
  logic [ID_W-1:0]  evt_id;
  logic [N_BTN-1:0] pending;
  logic [CW-1:0]    count;
  logic             overflow;

  modport master (
    output enable, btn_edge, evt_ready, clr_ovf,
    input  evt_valid, evt_id, pending, count, overflow
  );

  modport slave (
    input  enable, btn_edge, evt_ready, clr_ovf,
    output evt_valid, evt_id, pending, count, overflow
  );
endinterface

// File: rtl/button_event_arbiter.sv
// Latches button press pulses as pending requests and serialises them,
// round-robin, into a small FIFO drained by a valid/ready consumer.

module button_event_pend_cell (
  input  logic clk,
  input  logic rst,
  input  logic cap,
  input  logic hit,
  output logic pend,
  output logic drop
);
  // A press landing on the cycle its request is granted replaces it.
  assign drop = cap & pend & ~hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend <= 1'b0;
    else     pend <= cap | (pend & ~hit);
  end
endmodule

module button_event_arbiter #(
  parameter int N_BTN = 4,
  parameter int DEPTH = 4,
  parameter int ID_W  = $clog2(N_BTN)
) (
  input logic           clk,
  input logic           rst,
  button_event_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [N_BTN-1:0] cap, hit, drop, pend;
  logic [ID_W-1:0]  ptr, cand;
  logic             found, pop, grant;
  logic [ID_W-1:0]  mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    cnt;
  logic             ovf;

  assign cap = {N_BTN{bus.enable}} & bus.btn_edge;

  for (genvar g = 0; g < N_BTN; g++) begin : g_lane
    button_event_pend_cell u_cell (
      .clk  (clk),
      .rst  (rst),
      .cap  (cap[g]),
      .hit  (hit[g]),
      .pend (pend[g]),
      .drop (drop[g])
    );
  end

  // First pending request scanning upward from ptr, wrapping at N_BTN.
  always_comb begin
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < N_BTN; k++) begin
      int idx;
      idx = (int'(ptr) + k) % N_BTN;
      if (!found && pend[idx]) begin
        found = 1'b1;
        cand  = ID_W'(idx);
      end
    end
  end

  assign pop   = (cnt != '0) & bus.evt_ready;
  assign grant = found & ((cnt < CW'(DEPTH)) | pop);

  always_comb begin
    hit = '0;
    if (grant) hit[cand] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < DEPTH; j++) mem[j] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ptr    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (grant) begin
        mem[wr_ptr] <= cand;
        wr_ptr      <= wr_ptr + 1'b1;
        ptr         <= (cand == ID_W'(N_BTN - 1)) ? '0 : cand + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({grant, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      // A drop in the same cycle as a clear keeps the flag set.
      if (|drop)            ovf <= 1'b1;
      else if (bus.clr_ovf) ovf <= 1'b0;
    end
  end

  assign bus.evt_valid = (cnt != '0);
  assign bus.evt_id    = mem[rd_ptr];
  assign bus.pending   = pend;
  assign bus.count     = cnt;
  assign bus.overflow  = ovf;
endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed checks of the button event arbiter: latency, round robin, full
// FIFO, re-press on grant, enable gating and asynchronous reset.
module tb_button_event_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  button_event_if #(.N_BTN(4), .DEPTH(4), .ID_W(2)) bif ();

  button_event_arbiter #(.N_BTN(4), .DEPTH(4), .ID_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  initial begin
    bif.enable    = 1'b1;
    bif.btn_edge  = 4'b0000;
    bif.evt_ready = 1'b0;
    bif.clr_ovf   = 1'b0;
    #12;
    chk("rst_valid",   32'(bif.evt_valid), 0);
    chk("rst_count",   32'(bif.count),     0);
    chk("rst_pending", 32'(bif.pending),   0);
    chk("rst_ovf",     32'(bif.overflow),  0);
    chk("rst_id",      32'(bif.evt_id),    0);
    rst = 1'b0;
    tick();

    // single press: visible two edges after the pulse
    bif.btn_edge = 4'b0100;
    tick();
    bif.btn_edge = 4'b0000;
    chk("sp_pend",  32'(bif.pending),   32'b0100);
    chk("sp_val0",  32'(bif.evt_valid), 0);
    tick();
    chk("sp_val1",  32'(bif.evt_valid), 1);
    chk("sp_id",    32'(bif.evt_id),    2);
    chk("sp_cnt1",  32'(bif.count),     1);
    bif.evt_ready = 1'b1;
    tick();
    bif.evt_ready = 1'b0;
    chk("sp_cnt0",  32'(bif.count),     0);
    chk("sp_val2",  32'(bif.evt_valid), 0);

    // round robin from ptr=0
    rst = 1'b1;
    #2;
    rst = 1'b0;
    bif.btn_edge  = 4'b1011;
    bif.evt_ready = 1'b1;
    tick();
    bif.btn_edge = 4'b0000;
    chk("rr_pend", 32'(bif.pending),   32'b1011);
    chk("rr_v0",   32'(bif.evt_valid), 0);
    tick();
    chk("rr_id0",  32'(bif.evt_id),    0);
    chk("rr_v1",   32'(bif.evt_valid), 1);
    tick();
    chk("rr_id1",  32'(bif.evt_id),    1);
    tick();
    chk("rr_id3",  32'(bif.evt_id),    3);
    chk("rr_cnt",  32'(bif.count),     1);
    tick();
    chk("rr_empty", 32'(bif.evt_valid), 0);
    bif.btn_edge = 4'b0011;
    tick();
    bif.btn_edge = 4'b0000;
    tick();
    chk("rr2_id0", 32'(bif.evt_id), 0);
    tick();
    chk("rr2_id1", 32'(bif.evt_id), 1);
    tick();
    chk("rr2_empty", 32'(bif.evt_valid), 0);

    // full FIFO (ptr now 2)
    bif.evt_ready = 1'b0;
    bif.btn_edge = 4'b0001; tick();
    bif.btn_edge = 4'b0010; tick();
    bif.btn_edge = 4'b0100; tick();
    bif.btn_edge = 4'b1000; tick();
    bif.btn_edge = 4'b0001; tick();
    bif.btn_edge = 4'b0000;
    chk("full_cnt",  32'(bif.count),   4);
    chk("full_pend", 32'(bif.pending), 32'b0001);
    tick();
    chk("full_hold", 32'(bif.pending), 32'b0001);
    chk("full_ovf0", 32'(bif.overflow), 0);
    bif.btn_edge = 4'b0001;
    tick();
    bif.btn_edge = 4'b0000;
    chk("full_ovf1", 32'(bif.overflow), 1);
    chk("full_cnt2", 32'(bif.count),    4);
    bif.evt_ready = 1'b1;
    tick();
    bif.evt_ready = 1'b0;
    chk("full_pp_cnt",  32'(bif.count),    4);
    chk("full_pp_pend", 32'(bif.pending),  0);
    chk("full_pp_head", 32'(bif.evt_id),   1);
    chk("full_sticky",  32'(bif.overflow), 1);
    bif.clr_ovf = 1'b1;
    tick();
    bif.clr_ovf = 1'b0;
    chk("ovf_clr", 32'(bif.overflow), 0);
    bif.evt_ready = 1'b1;
    tick();
    chk("drain_2", 32'(bif.evt_id), 2);
    tick();
    chk("drain_3", 32'(bif.evt_id), 3);
    tick();
    chk("drain_0", 32'(bif.evt_id), 0);
    tick();
    chk("drain_cnt", 32'(bif.count), 0);
    bif.evt_ready = 1'b0;

    // grant and re-press of button 1 in the same cycle
    bif.btn_edge = 4'b0010;
    tick();
    tick();
    bif.btn_edge = 4'b0000;
    chk("rp_pend", 32'(bif.pending),  32'b0010);
    chk("rp_ovf",  32'(bif.overflow), 0);
    chk("rp_cnt1", 32'(bif.count),    1);
    tick();
    chk("rp_cnt2", 32'(bif.count),    2);
    chk("rp_pend0", 32'(bif.pending), 0);
    bif.evt_ready = 1'b1;
    chk("rp_id_a", 32'(bif.evt_id), 1);
    tick();
    chk("rp_id_b", 32'(bif.evt_id), 1);
    chk("rp_cnt3", 32'(bif.count),  1);
    tick();
    chk("rp_empty", 32'(bif.count), 0);
    bif.evt_ready = 1'b0;

    // enable=0 blocks capture but not draining
    bif.btn_edge = 4'b0100;
    tick();
    bif.btn_edge = 4'b0000;
    tick();
    chk("en_q", 32'(bif.count), 1);
    bif.enable   = 1'b0;
    bif.btn_edge = 4'b1111;
    tick();
    chk("en_pend", 32'(bif.pending), 0);
    chk("en_cnt",  32'(bif.count),   1);
    tick();
    chk("en_pend2", 32'(bif.pending), 0);
    chk("en_ovf",   32'(bif.overflow), 0);
    bif.btn_edge  = 4'b0000;
    bif.evt_ready = 1'b1;
    chk("en_head", 32'(bif.evt_id), 2);
    tick();
    chk("en_pop", 32'(bif.evt_valid), 0);
    bif.evt_ready = 1'b0;
    bif.enable    = 1'b1;

    // async reset with count=3, pending=0110 (ptr now 3)
    bif.btn_edge = 4'b1111;
    tick();
    bif.btn_edge = 4'b0000;
    tick();
    tick();
    bif.btn_edge = 4'b0010;
    tick();
    bif.btn_edge = 4'b0000;
    chk("ar_cnt",  32'(bif.count),   3);
    chk("ar_pend", 32'(bif.pending), 32'b0110);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_z_cnt",  32'(bif.count),     0);
    chk("ar_z_val",  32'(bif.evt_valid), 0);
    chk("ar_z_id",   32'(bif.evt_id),    0);
    chk("ar_z_pend", 32'(bif.pending),   0);
    chk("ar_z_ovf",  32'(bif.overflow),  0);
    #1;
    rst = 1'b0;
    bif.btn_edge = 4'b1000;
    tick();
    bif.btn_edge = 4'b0000;
    chk("ar_pend1", 32'(bif.pending), 32'b1000);
    tick();
    chk("ar_val", 32'(bif.evt_valid), 1);
    chk("ar_id",  32'(bif.evt_id),    3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
